// File: rtl/fixed_to_ascii_conv_pkg.sv
// Shared types and constants for the fixed-point to ASCII decimal converter.
package fixed_ascii_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ABS,
        INT,
        FRAC,
        ROUND,
        DONE
    } conv_state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;

    // Accept edge to o_valid rising edge, in clock cycles.
    function automatic int conv_latency(input int int_bits, input int disp_frac, input bit round_en);
        return 1 + int_bits + disp_frac + (round_en ? 2 : 0);
    endfunction

endpackage

// File: rtl/fixed_to_ascii_conv_if.sv
// Value-in / string-out handshake bundle; slave is the converter side.
interface fixed_to_ascii_conv_if #(
    parameter int BITS  = 33,
    parameter int CHARS = 8
);
    logic                 i_valid;
    logic                 o_ready;
    logic [BITS-1:0]      i_value;
    logic                 o_valid;
    logic                 i_ready;
    logic [CHARS*8-1:0]   o_chars;
    logic                 o_ovf;

    modport slave (
        input  i_valid, i_value, i_ready,
        output o_ready, o_valid, o_chars, o_ovf
    );

    modport master (
        output i_valid, i_value, i_ready,
        input  o_ready, o_valid, o_chars, o_ovf
    );
endinterface

// File: rtl/fixed_to_ascii_conv_bcd_digit_step.sv
// One double-dabble cell: add 3 when the digit is >= 5, then shift left one bit.
module bcd_digit_step (
    input  logic [3:0] digit_in,
    input  logic       carry_in,
    output logic [3:0] digit_out,
    output logic       carry_out
);
    logic [3:0] adj;

    assign adj       = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;
    assign digit_out = {adj[2:0], carry_in};
    assign carry_out = adj[3];
endmodule

// File: rtl/fixed_to_ascii_conv.sv
// Multi-cycle signed Q(INT_BITS).(FRAC_BITS) to "<sign><int>.<frac>" ASCII converter.
// Define FIXED_TO_ASCII_ROUND_EN for round-half-up via a guard digit; otherwise truncates.
module fixed_to_ascii_conv
    import fixed_ascii_pkg::*;
#(
    parameter int INT_BITS  = 3,
    parameter int FRAC_BITS = 30,
    parameter int DISP_INT  = 2,
    parameter int DISP_FRAC = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    fixed_to_ascii_conv_if.slave  bus
);
    localparam int BITS  = INT_BITS + FRAC_BITS;
    localparam int CHARS = DISP_INT + DISP_FRAC + 2;
`ifdef FIXED_TO_ASCII_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif
    localparam int FDIG  = DISP_FRAC + (ROUND_EN ? 1 : 0);
    localparam int NBCD  = DISP_INT + 1;
    localparam int CNT_W = $clog2(conv_latency(INT_BITS, DISP_FRAC, ROUND_EN) + 1);

    function automatic logic [CHARS*8-1:0] idle_chars();
        logic [CHARS*8-1:0] s;
        s = {CHARS{ASCII_ZERO}};
        s[CHARS*8-1 -: 8]  = ASCII_PLUS;
        s[DISP_FRAC*8 +: 8] = ASCII_DOT;
        return s;
    endfunction

    localparam logic [CHARS*8-1:0] IDLE_CHARS = idle_chars();

    conv_state_t          state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [BITS-1:0]      value_reg;
    logic                 sign_reg;
    logic [INT_BITS-1:0]  int_sh_reg;
    logic [FRAC_BITS-1:0] frac_f_reg;
    logic [NBCD*4-1:0]    bcd_reg;
    logic                 carry_ovf_reg;
    logic [FDIG*4-1:0]    frac_dig_reg;
    logic [CHARS*8-1:0]   chars_reg;
    logic                 ovf_reg;
    logic                 valid_reg;
    logic                 ready_reg;

    // Magnitude as unsigned BITS-wide, so the most negative input stays exact.
    logic [BITS-1:0] mag;
    assign mag = value_reg[BITS-1] ? (~value_reg + 1'b1) : value_reg;

    logic [NBCD*4-1:0] bcd_next;
    logic [NBCD:0]     dd_carry;
    assign dd_carry[0] = int_sh_reg[INT_BITS-1];

    for (genvar gi = 0; gi < NBCD; gi++) begin : g_dd
        bcd_digit_step u_step (
            .digit_in  (bcd_reg[gi*4 +: 4]),
            .carry_in  (dd_carry[gi]),
            .digit_out (bcd_next[gi*4 +: 4]),
            .carry_out (dd_carry[gi+1])
        );
    end

    logic [FRAC_BITS+3:0] f10;
    logic [FDIG*4-1:0]    frac_dig_next;
    assign f10 = ({4'b0000, frac_f_reg} << 3) + ({4'b0000, frac_f_reg} << 1);

    always_comb begin
        frac_dig_next      = frac_dig_reg << 4;
        frac_dig_next[3:0] = f10[FRAC_BITS+3:FRAC_BITS];
    end

    logic [DISP_INT*4-1:0]  res_int;
    logic [DISP_FRAC*4-1:0] res_frac;
    logic                   res_ovf;
    logic                   rnd_carry;

    // Final digits: truncating build takes the digit produced this cycle,
    // rounding build ripples +1 from the guard digit up through every displayed digit.
    always_comb begin
        res_int   = bcd_reg[DISP_INT*4-1:0];
        res_frac  = frac_dig_next[DISP_FRAC*4-1:0];
        res_ovf   = carry_ovf_reg | (bcd_reg[NBCD*4-1 -: 4] != 4'd0);
        rnd_carry = 1'b0;
        if (ROUND_EN) begin
            res_frac  = frac_dig_reg[FDIG*4-1 -: DISP_FRAC*4];
            rnd_carry = (frac_dig_reg[3:0] >= 4'd5);
            for (int i = 0; i < DISP_FRAC; i++) begin
                if (rnd_carry) begin
                    if (res_frac[i*4 +: 4] == 4'd9) begin
                        res_frac[i*4 +: 4] = 4'd0;
                    end else begin
                        res_frac[i*4 +: 4] = res_frac[i*4 +: 4] + 4'd1;
                        rnd_carry = 1'b0;
                    end
                end
            end
            for (int i = 0; i < DISP_INT; i++) begin
                if (rnd_carry) begin
                    if (res_int[i*4 +: 4] == 4'd9) begin
                        res_int[i*4 +: 4] = 4'd0;
                    end else begin
                        res_int[i*4 +: 4] = res_int[i*4 +: 4] + 4'd1;
                        rnd_carry = 1'b0;
                    end
                end
            end
            res_ovf = res_ovf | rnd_carry;
        end
    end

    logic [CHARS*8-1:0] chars_build;
    always_comb begin
        chars_build = IDLE_CHARS;
        chars_build[CHARS*8-1 -: 8] = sign_reg ? ASCII_MINUS : ASCII_PLUS;
        for (int i = 0; i < DISP_INT; i++) begin
            chars_build[(DISP_FRAC+1+i)*8 +: 8] =
                ASCII_ZERO + (res_ovf ? 8'd9 : {4'b0000, res_int[i*4 +: 4]});
        end
        for (int i = 0; i < DISP_FRAC; i++) begin
            chars_build[i*8 +: 8] =
                ASCII_ZERO + (res_ovf ? 8'd9 : {4'b0000, res_frac[i*4 +: 4]});
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            value_reg     <= '0;
            sign_reg      <= 1'b0;
            int_sh_reg    <= '0;
            frac_f_reg    <= '0;
            bcd_reg       <= '0;
            carry_ovf_reg <= 1'b0;
            frac_dig_reg  <= '0;
            chars_reg     <= IDLE_CHARS;
            ovf_reg       <= 1'b0;
            valid_reg     <= 1'b0;
            ready_reg     <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.i_valid) begin
                        value_reg <= bus.i_value;
                        ready_reg <= 1'b0;
                        state_reg <= ABS;
                    end
                end
                ABS: begin
                    sign_reg      <= value_reg[BITS-1];
                    int_sh_reg    <= mag[BITS-1:FRAC_BITS];
                    frac_f_reg    <= mag[FRAC_BITS-1:0];
                    bcd_reg       <= '0;
                    carry_ovf_reg <= 1'b0;
                    frac_dig_reg  <= '0;
                    cnt_reg       <= '0;
                    state_reg     <= INT;
                end
                INT: begin
                    bcd_reg       <= bcd_next;
                    carry_ovf_reg <= carry_ovf_reg | dd_carry[NBCD];
                    int_sh_reg    <= int_sh_reg << 1;
                    if (cnt_reg == CNT_W'(INT_BITS - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= FRAC;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                FRAC: begin
                    frac_dig_reg <= frac_dig_next;
                    frac_f_reg   <= f10[FRAC_BITS-1:0];
                    if (cnt_reg == CNT_W'(FDIG - 1)) begin
                        cnt_reg <= '0;
                        if (ROUND_EN) begin
                            state_reg <= ROUND;
                        end else begin
                            chars_reg <= chars_build;
                            ovf_reg   <= res_ovf;
                            valid_reg <= 1'b1;
                            state_reg <= DONE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ROUND: begin
                    chars_reg <= chars_build;
                    ovf_reg   <= res_ovf;
                    valid_reg <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    if (bus.i_ready) begin
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.o_ready = ready_reg;
    assign bus.o_valid = valid_reg;
    assign bus.o_chars = chars_reg;
    assign bus.o_ovf   = ovf_reg;

endmodule
